// File: rtl/sort_pkg.sv
// sort_pkg: shared types and helpers for the sort sequencer slice.
// Holds the FSM state encoding and slot slicing arithmetic.
package sort_pkg;

  localparam int N_BITS_DEF    = 8;
  localparam int K_NUMBERS_DEF = 49;
  localparam int IDX_W         = $clog2(K_NUMBERS_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  function automatic int slot_off(
    input int slot,
    input int n_bits
  );
    return slot * n_bits;
  endfunction

endpackage

// File: rtl/sort_drain_mux.sv
// sort_drain_mux: selects one sorter slot for the output stream.
// Output is forced to zero when not enabled.
module sort_drain_mux
  import sort_pkg::*;
#(
  parameter int N_BITS    = 8,
  parameter int K_NUMBERS = 49,
  parameter int IW        = 6
) (
  input  logic [K_NUMBERS*N_BITS-1:0] readdata_i,
  input  logic [IW-1:0]               idx,
  input  logic                        en,
  output logic [N_BITS-1:0]           data,
  output logic                        last
);

  // slot select, zero outside the drain phase
  always_comb begin
    data = '0;
    for (int k = 0; k < K_NUMBERS; k++) begin
      if (en && idx == IW'(k)) begin
        data = readdata_i[slot_off(k, N_BITS) +: N_BITS];
      end
    end
  end

  assign last = en && (idx == IW'(K_NUMBERS - 1));

endmodule

// File: rtl/sort_sequencer.sv
// sort_sequencer: loads, starts and drains one bubble sorter.
// The last load strobe is allowed to land before start is pulsed.
module sort_sequencer
  import sort_pkg::*;
#(
  parameter int N_BITS         = 8,
  parameter int K_NUMBERS      = 49,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_BITS-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_BITS-1:0]           out_data,
  output logic                        out_last,
  input  logic                        abort_i,
  output logic                        busy_o,
  output logic                        error_o,
  output logic [K_NUMBERS-1:0]        load_o,
  output logic [K_NUMBERS*N_BITS-1:0] writedata_o,
  output logic                        start_o,
  input  logic                        done_i,
  input  logic [K_NUMBERS*N_BITS-1:0] readdata_i
);

  localparam int IW = (K_NUMBERS > 1) ? $clog2(K_NUMBERS) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST = IW'(K_NUMBERS - 1);
  localparam logic [WW-1:0] WEND = WW'(TIMEOUT_CYCLES - 1);

  state_t                        state, state_n;
  logic [IW-1:0]                 idx, idx_n;
  logic [WW-1:0]                 wcnt, wcnt_n;
  logic [K_NUMBERS-1:0]          load_q, load_n;
  logic [K_NUMBERS*N_BITS-1:0]   wdata_q, wdata_n;
  logic                          err_q, err_n;
  logic                          acc;
  logic                          abort_hit;
  logic                          last_ld;

  assign abort_hit = abort_i && (state != ST_IDLE);
  assign last_ld   = load_q[K_NUMBERS-1];
  assign in_ready  = !rst && !abort_hit &&
                     ((state == ST_IDLE) ||
                      (state == ST_LOAD && !last_ld));
  assign acc       = in_valid && in_ready;

  assign out_valid   = (state == ST_DRAIN);
  assign busy_o      = (state != ST_IDLE);
  assign start_o     = (state == ST_START);
  assign error_o     = err_q;
  assign load_o      = load_q;
  assign writedata_o = wdata_q;

  sort_drain_mux #(
    .N_BITS    (N_BITS),
    .K_NUMBERS (K_NUMBERS),
    .IW        (IW)
  ) u_mux (
    .readdata_i (readdata_i),
    .idx        (idx),
    .en         (out_valid),
    .data       (out_data),
    .last       (out_last)
  );

  // next state, counters and load strobes
  always_comb begin
    state_n = state;
    idx_n   = idx;
    wcnt_n  = wcnt;
    load_n  = '0;
    wdata_n = wdata_q;
    err_n   = err_q;
    if (acc) begin
      load_n[idx] = 1'b1;
      wdata_n     = {K_NUMBERS{in_data}};
      err_n       = 1'b0;
      if (idx != LAST) idx_n = idx + 1'b1;
    end
    unique case (state)
      ST_IDLE: begin
        if (acc) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        if (last_ld) state_n = ST_START;
      end
      ST_START: begin
        state_n = ST_WAIT;
        wcnt_n  = '0;
      end
      ST_WAIT: begin
        if (done_i) begin
          state_n = ST_DRAIN;
          idx_n   = '0;
        end else if (wcnt == WEND) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
          wcnt_n  = '0;
          idx_n   = '0;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx == LAST) begin
            state_n = ST_IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      wcnt_n  = '0;
      load_n  = '0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      wcnt    <= '0;
      load_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      wcnt    <= wcnt_n;
      load_q  <= load_n;
      wdata_q <= wdata_n;
      err_q   <= err_n;
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// tb_sort_sequencer: scoreboard bench for sort_sequencer.
// A behavioural sorter model answers start with done.
module tb_sort_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        abort_i;
  logic        busy_o;
  logic        error_o;
  logic [3:0]  load_o;
  logic [31:0] writedata_o;
  logic        start_o;
  logic        done_i;
  logic [31:0] readdata_i;

  logic [3:0][7:0] slot;
  logic            armed;
  int              cnt;
  int              done_delay;
  int              ready_mode;

  int n_checks;
  int n_fail;
  int n_out;
  int start_cnt;

  logic [8:0]  exp_q[$];
  logic [11:0] ld_q[$];

  logic       stall_pend;
  logic [7:0] stall_data;
  logic       prev_ld3;
  logic       prev_start;

  sort_sequencer #(
    .N_BITS         (8),
    .K_NUMBERS      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .error_o     (error_o),
    .load_o      (load_o),
    .writedata_o (writedata_o),
    .start_o     (start_o),
    .done_i      (done_i),
    .readdata_i  (readdata_i)
  );

  always #5 clk = ~clk;

  assign readdata_i = slot;

  function automatic logic [3:0][7:0] sort4(
    input logic [3:0][7:0] a
  );
    logic [3:0][7:0] r;
    logic [7:0]      t;
    r = a;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (r[j] > r[j+1]) begin
          t      = r[j];
          r[j]   = r[j+1];
          r[j+1] = t;
        end
    return r;
  endfunction

  // behavioural sorter: loads slots, sorts and pulses done
  always @(posedge clk) begin
    done_i <= 1'b0;
    if (rst) begin
      armed <= 1'b0;
      cnt   <= 0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (load_o[k]) slot[k] <= writedata_o[k*8 +: 8];
      if (start_o) begin
        armed <= 1'b1;
        cnt   <= 0;
      end else if (armed) begin
        if (cnt == done_delay) begin
          armed  <= 1'b0;
          done_i <= 1'b1;
          slot   <= sort4(slot);
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1:       out_ready = ~out_ready;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // output and load monitor
  initial begin
    logic [8:0]  e;
    logic [11:0] l;
    stall_pend = 1'b0;
    prev_ld3   = 1'b0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (stall_pend) chk("stall_stable", out_data, stall_data);
        if (out_ready) begin
          stall_pend = 1'b0;
          n_out++;
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", {out_last, out_data}, e);
          end
        end else begin
          stall_pend = 1'b1;
          stall_data = out_data;
        end
      end else begin
        stall_pend = 1'b0;
      end
      if (load_o != 4'b0) begin
        if (ld_q.size() == 0) begin
          chk("unexpected_load", 1, 0);
        end else begin
          l = ld_q.pop_front();
          chk("load_o", load_o, l[11:8]);
          chk("writedata_o", writedata_o, {4{l[7:0]}});
        end
      end
      if (start_o) begin
        start_cnt++;
        chk("start_after_load", {prev_ld3, prev_start}, 2'b10);
      end
      prev_ld3   = load_o[3];
      prev_start = start_o;
    end
  end

  task automatic send(
    input logic [7:0] w,
    input int         s,
    input int         gap
  );
    int t;
    logic [3:0] oh;
    oh = 4'b0001 << s;
    ld_q.push_back({oh, w});
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 50) chk("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic job(
    input logic [31:0] w,
    input logic [31:0] srt,
    input int          gap
  );
    for (int i = 0; i < 4; i++)
      exp_q.push_back({i == 3, srt[i*8 +: 8]});
    for (int i = 0; i < 4; i++)
      send(w[i*8 +: 8], i, gap);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    #1;
    while (busy_o && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk(name, busy_o, 0);
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (!start_o && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("start_seen", start_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int sc;
    int no;
    n_checks   = 0;
    n_fail     = 0;
    n_out      = 0;
    start_cnt  = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    abort_i    = 1'b0;
    done_delay = 2;
    ready_mode = 0;
    slot       = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {in_ready, out_valid, out_last, busy_o, error_o,
         start_o, load_o, out_data, writedata_o},
        0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {in_ready, busy_o}, 2'b10);

    // basic job, back-to-back input, ready always high
    job(32'h20_40_10_30, 32'h40_30_20_10, 0);
    wait_idle("job1_idle");
    chk("job1_drained", exp_q.size(), 0);

    // gapped input, toggling out_ready
    ready_mode = 1;
    job(32'h20_40_10_30, 32'h40_30_20_10, 1);
    wait_idle("job2_idle");
    chk("job2_drained", exp_q.size(), 0);
    ready_mode = 0;

    // timeout: sorter never answers
    done_delay = -1;
    for (int i = 0; i < 4; i++)
      send(8'(8'h11 * (i + 1)), i, 0);
    wait_start();
    n = 0;
    @(negedge clk);
    #1;
    while (!error_o && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("timeout_wait_cycles", n, 16);
    chk("timeout_state", {error_o, busy_o}, 2'b10);
    @(negedge clk);
    chk("error_sticky", error_o, 1);
    done_delay = 2;
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h03});
    exp_q.push_back({1'b0, 8'h05});
    exp_q.push_back({1'b1, 8'h09});
    send(8'h05, 0, 0);
    chk("error_cleared", error_o, 0);
    send(8'h03, 1, 0);
    send(8'h09, 2, 0);
    send(8'h01, 3, 0);
    wait_idle("job3_idle");
    chk("job3_drained", exp_q.size(), 0);

    // abort after two words
    sc = start_cnt;
    send(8'h77, 0, 0);
    send(8'h66, 1, 0);
    #1;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    #1;
    chk("abort_load_idle", {busy_o, load_o}, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_start", start_cnt, sc);
    job(32'h04_03_02_01, 32'h04_03_02_01, 0);
    wait_idle("job4_idle");
    chk("job4_drained", exp_q.size(), 0);

    // abort in wait, late done must be ignored
    done_delay = 6;
    no = n_out;
    for (int i = 0; i < 4; i++)
      send(8'(8'h50 - i), i, 0);
    wait_start();
    @(negedge clk);
    @(negedge clk);
    #1;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    #1;
    chk("abort_wait_idle", busy_o, 0);
    repeat (12) @(negedge clk);
    chk("late_done_ignored", {out_valid, n_out}, {1'b0, no});
    done_delay = 2;

    // reset while draining slot 2
    job(32'h0c_0a_0d_0b, 32'h0d_0c_0b_0a, 0);
    n = 0;
    @(negedge clk);
    #1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_seen", out_valid, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("drain_idx2", {out_valid, out_data}, {1'b1, 8'h0c});
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_drain",
        {out_valid, busy_o, load_o, out_data}, 0);
    rst = 1'b0;
    chk("rst_left_one", exp_q.size(), 1);
    exp_q.delete();
    job(32'h01_ff_80_7f, 32'hff_80_7f_01, 0);
    wait_idle("job6_idle");
    chk("job6_drained", exp_q.size(), 0);

    repeat (4) @(negedge clk);
    chk("loads_consumed", ld_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
